// File: rtl/chunked_carry_adder_if.sv
// Operand/result bundle for chunked_carry_adder: start/busy/done handshake plus data.
interface chunked_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/chunked_carry_adder.sv
// Multi-cycle adder/subtractor resolving CHUNK bits per clock through one registered carry.
// Define OVERFLOW_EN to generate the registered signed-overflow flag; otherwise ovf is tied 0.
module chunked_carry_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_carry_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             c_out_r, done_r;
    logic             load, step, last;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             carry_next;

    // Explicit full-adder cells keep the carry path a ripple of exactly CHUNK stages.
    function automatic logic [CHUNK:0] ripple_add(input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y,
                                                  input logic             ci);
        logic             c;
        logic [CHUNK-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    assign last    = (idx == IDX_W'(NCHUNK - 1));
    assign a_chunk = a_r[idx*CHUNK +: CHUNK];
    assign b_chunk = b_r[idx*CHUNK +: CHUNK];
    assign {carry_next, s_chunk} = ripple_add(a_chunk, b_chunk, carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= step && last;
            if (load) begin
                // Subtract is a + ~b + 1, so c_in is replaced by the forced carry.
                a_r   <= bus.a;
                b_r   <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub ? 1'b1 : bus.c_in;
                idx   <= '0;
            end else if (step) begin
                sum_r[idx*CHUNK +: CHUNK] <= s_chunk;
                carry <= carry_next;
                idx   <= last ? '0 : idx + 1'b1;
                if (last) c_out_r <= carry_next;
            end
        end
    end

    assign bus.busy  = (state == BUSY);
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;

`ifdef OVERFLOW_EN
    logic ovf_r;
    logic msb_cin;

    // Carry into the MSB recovered from its sum bit: s = x ^ y ^ cin.
    assign msb_cin = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             ovf_r <= 1'b0;
        else if (load)          ovf_r <= 1'b0;
        else if (step && last)  ovf_r <= msb_cin ^ carry_next;
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_chunked_carry_adder.sv
// Scoreboard bench for chunked_carry_adder (WIDTH=16, CHUNK=4) with directed vectors.
module tb_chunked_carry_adder;
`ifdef OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;
    int   prev_done = -1;
    bit   btb_mode = 1'b0;
    exp_t exp_q[$];

    chunked_carry_adder_if #(.WIDTH(16)) bus ();

    chunked_carry_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the oldest expectation whenever done is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (!btb_mode) prev_done = -1;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.sum), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("c_out", 32'(bus.c_out), 32'(e.c_out));
                    check("ovf", 32'(bus.ovf), 32'(e.ovf));
                    check("busy_cycles", busy_cnt, 4);
                end
                if (btb_mode) begin
                    if (prev_done >= 0) check("done_spacing", cyc - prev_done, 5);
                    prev_done = cyc;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 0);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, input bit push, input logic [15:0] es,
                         input logic ec, input logic eo);
        wait_idle();
        bus.a     = ta;
        bus.b     = tb_v;
        bus.c_in  = tc;
        bus.sub   = ts;
        bus.start = 1'b1;
        if (push) exp_q.push_back('{es, ec, eo & OVF_ON});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_c_out", 32'(bus.c_out), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h0FF0, 1'b0, 1'b0, 1, 16'h2224, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1, 16'h0002, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1);

        // Start pulse mid-operation must be ignored.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Start held high, operands changing every 5 cycles.
        wait_idle();
        @(negedge clk);
        btb_mode = 1'b1;
        bus.c_in = 1'b0;
        bus.sub  = 1'b0;
        bus.start = 1'b1;
        bus.a = 16'h0101; bus.b = 16'h0202; exp_q.push_back('{16'h0303, 1'b0, 1'b0});
        repeat (5) @(negedge clk);
        bus.a = 16'h8000; bus.b = 16'h8000; exp_q.push_back('{16'h0000, 1'b1, OVF_ON});
        repeat (5) @(negedge clk);
        bus.a = 16'h4000; bus.b = 16'h4000; exp_q.push_back('{16'h8000, 1'b0, OVF_ON});
        repeat (5) @(negedge clk);
        bus.a = 16'h00FF; bus.b = 16'h0F01; exp_q.push_back('{16'h1000, 1'b0, 1'b0});
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        btb_mode = 1'b0;

        // Reset two cycles into an operation: no done, everything cleared at once.
        issue(16'h1234, 16'h0FF0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_sum", 32'(bus.sum), 0);
        check("abort_c_out", 32'(bus.c_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/chunked_carry_adder.md
# chunked_carry_adder

Multi-cycle, parametrised ripple-carry adder/subtractor that resolves a WIDTH-bit addition CHUNK bits per clock. A single registered carry is passed between chunks, so the combinational carry chain is limited to CHUNK full-adder cells rather than WIDTH. It sits in the datapath wherever a wide add or subtract is needed and the full-width ripple would not close timing. It is the sequential, width-generic successor to the fixed 5-bit ripple-carry adder, and adds subtract mode, a start/busy/done handshake and an optional overflow flag.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- CHUNK, 4, bits resolved per cycle; WIDTH must be an integer multiple of CHUNK.
- NCHUNK, WIDTH/CHUNK, a derived localparam and not overridable.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled only when busy==0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in; used only when sub==0.
- sub  in  1  0: a+b+c_in; 1: a−b (computed as a+~b+1, c_in ignored).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held until the next accepted start completes.
- c_out  out  1  carry out of the MSB (for sub, 1 means no borrow).
- ovf  out  1  signed overflow (see Configuration).

## Operation
- State machine has two states, IDLE and BUSY, plus the chunk index idx (⌈log2 NCHUNK⌉ bits, minimum 1).
- IDLE: on an edge with start==1, the block captures the operands:
  - a_r ← a.
  - b_r ← sub ? ~b : b.
  - carry ← sub ? 1 : c_in.
  - idx ← 0; busy ← 1; state ← BUSY.
- BUSY, each edge:
  - Compute chunk idx, {carry', s} = a_r[idx] + b_r[idx] + carry, using ripple full-adder cells.
  - sum[idx*CHUNK +: CHUNK] ← s; carry ← carry'; idx ← idx+1.
- Last chunk (idx==NCHUNK−1), on the same edge:
  - c_out ← carry'; done ← 1; busy ← 0; state ← IDLE.
- done is cleared on the following edge.
- Capture is gated by busy==0. This includes the edge where done is asserted, so back-to-back operations are allowed.
- start while busy==1 is ignored and is neither queued nor flagged.
- sum updates progressively during BUSY. It is guaranteed valid only while done==1 and thereafter until the next start is accepted.
- a, b, c_in and sub are don't-care except on the accepting edge.
- NCHUNK==1 (CHUNK==WIDTH) degenerates correctly to 2-cycle latency.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, c_out=0, ovf=0, a_r=b_r=0.
- Latency: start accepted at edge k; chunks are processed at edges k+1..k+NCHUNK; done is high from edge k+NCHUNK to edge k+NCHUNK+1.
- Throughput: one operation per NCHUNK+1 cycles when start is held high.
- busy rises at edge k and falls at edge k+NCHUNK, the same edge where done rises.
- Reset asserted mid-operation aborts the operation immediately. done is not pulsed. After release the block is in IDLE with all outputs zero.
- Reset release is synchronous to the design, and the first start is sampled at the first rising edge after rst_n goes high.
- Critical path: carry register → CHUNK full-adder cells → carry/sum registers.

## Configuration
- OVERFLOW_EN defined:
  - ovf ← carry_into_MSB XOR carry_out_of_MSB, registered on the done edge.
  - ovf is held with sum and cleared to 0 when a new start is accepted.
- OVERFLOW_EN undefined:
  - The ovf port remains present and is tied constant 0.
  - No MSB-carry logic is generated.

## Test plan
- WIDTH=16, CHUNK=4: a=0x1234, b=0x0FF0, c_in=0, sub=0.
  - Required: busy high for 4 cycles, done at edge k+4, sum=0x2224, c_out=0.
- Full ripple: a=0xFFFF, b=0x0001, c_in=0.
  - Required: sum=0x0000, c_out=1 (carry crosses all 4 chunks).
  - With c_in=1 and b=0x0000: sum=0x0000, c_out=1.
- Subtract: a=0x0005, b=0x0007, sub=1, c_in=1 (must be ignored).
  - Required: sum=0xFFFE, c_out=0.
  - With a=0x0007, b=0x0005: sum=0x0002, c_out=1.
- Overflow, OVERFLOW_EN defined: a=0x7FFF, b=0x0001.
  - Required: sum=0x8000, ovf=1.
  - a=0x8000, b=0x0001, sub=1: sum=0x7FFF, ovf=1.
  - Same stimulus with OVERFLOW_EN undefined: ovf=0 throughout.
- Handshake: start held high continuously with new operands every 5 cycles.
  - Required: one done per 5 cycles and results in order.
  - A start pulse at edge k+2 mid-operation is ignored; the next result is unchanged.
- Reset mid-operation: assert rst_n=0 two cycles after start.
  - Required: busy, done, sum and c_out drop to 0 immediately, with no done pulse.
  - After release, a fresh 0x0001+0x0001 yields sum=0x0002 with 4-cycle busy.
